// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: FSM state encodings, MUL opcode and default datapath width.
package cpu_defs;

   localparam int unsigned WIDTH_D_DEF = 32;
   localparam logic [5:0]  OP_MUL      = 6'b011100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mul_state_e;

endpackage

// File: rtl/mult_shift_add.sv
// Radix-2 shift-add datapath: accumulator, shifting multiplicand and multiplier.
// With MULT_EARLY_EXIT_EN defined it also reports when the multiplier runs out of ones.
module mult_shift_add
   import cpu_defs::*;
#(
   parameter int unsigned WIDTH_D = WIDTH_D_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic               step,
   input  logic [WIDTH_D-1:0] mcand_i,
   input  logic [WIDTH_D-1:0] mplier_i,
`ifdef MULT_EARLY_EXIT_EN
   output logic               mplier_zero,
`endif
   output logic [WIDTH_D-1:0] acc_o
);

   logic [WIDTH_D-1:0] acc_q, acc_d;
   logic [WIDTH_D-1:0] mcand_q, mcand_d;
   logic [WIDTH_D-1:0] mplier_q, mplier_d;

   // Next-state: load clears the accumulator, step performs one iteration.
   always_comb begin
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      if (load) begin
         acc_d    = '0;
         mcand_d  = mcand_i;
         mplier_d = mplier_i;
      end else if (step) begin
         if (mplier_q[0]) acc_d = acc_q + mcand_q;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
      end
   end

   // Datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
      end else begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
      end
   end

`ifdef MULT_EARLY_EXIT_EN
   // High when the multiplier will be zero after the iteration in progress.
   assign mplier_zero = (mplier_q[WIDTH_D-1:1] == '0);
`endif

   assign acc_o = acc_q;

endmodule

// File: rtl/mult_seq_ctrl.sv
// EX-stage sequencer for the iterative MUL: FSM, iteration counter, stall/flush
// handling and result registers. Optional MULT_EARLY_EXIT_EN ends the multiply
// once the remaining multiplier bits are all zero.
module mult_seq_ctrl
   import cpu_defs::*;
#(
   parameter int unsigned WIDTH_D = WIDTH_D_DEF,
   parameter int unsigned CNT_W   = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ex_valid,
   input  logic               mult_sel,
   input  logic               flush,
   input  logic [WIDTH_D-1:0] src_a,
   input  logic [WIDTH_D-1:0] src_b,
   output logic               stall,
   output logic               busy,
   output logic               res_valid,
   output logic [WIDTH_D-1:0] res
);

   mul_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH_D-1:0] res_q;
   logic [WIDTH_D-1:0] acc;
   logic               start, load, step;
`ifdef MULT_EARLY_EXIT_EN
   logic               mplier_zero;
`endif

   assign start = ex_valid & mult_sel & ~flush;

   mult_shift_add #(.WIDTH_D(WIDTH_D)) u_dp (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .step       (step),
      .mcand_i    (src_a),
      .mplier_i   (src_b),
`ifdef MULT_EARLY_EXIT_EN
      .mplier_zero(mplier_zero),
`endif
      .acc_o      (acc)
   );

   // Next-state and datapath controls; DONE ignores start since the same
   // stalled instruction is still sitting in EX.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      load    = 1'b0;
      step    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               load    = 1'b1;
               cnt_d   = '0;
               state_d = BUSY;
`ifdef MULT_EARLY_EXIT_EN
               if (src_b == '0) state_d = DONE;
`endif
            end
         end
         BUSY: begin
            step  = 1'b1;
            cnt_d = cnt_q + CNT_W'(1);
            if (flush)
               state_d = IDLE;
            else if (cnt_q == CNT_W'(WIDTH_D-1))
               state_d = DONE;
`ifdef MULT_EARLY_EXIT_EN
            else if (mplier_zero)
               state_d = DONE;
`endif
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State, counter and held-result registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (state_q == DONE && !flush) res_q <= acc;
      end
   end

   // Outputs are forced low during reset and by flush where applicable.
   assign stall     = rst_n & ~flush & (((state_q == IDLE) & start) | (state_q == BUSY));
   assign busy      = rst_n & (state_q != IDLE);
   assign res_valid = rst_n & ~flush & (state_q == DONE);
   assign res       = (state_q == DONE) ? acc : res_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: directed cases plus random multiplies
// checked against an arithmetic reference (product and expected latency).
module tb_mult_seq_ctrl;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         ex_valid = 1'b0, mult_sel = 1'b0, flush = 1'b0;
   logic [W-1:0] src_a = '0, src_b = '0;
   logic         stall, busy, res_valid;
   logic [W-1:0] res;

   int checks = 0;
   int failures = 0;

   mult_seq_ctrl dut (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .mult_sel(mult_sel),
      .flush(flush), .src_a(src_a), .src_b(src_b),
      .stall(stall), .busy(busy), .res_valid(res_valid), .res(res)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: low W bits of the unsigned product.
   function automatic logic [W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [2*W-1:0] p;
      p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      return p[W-1:0];
   endfunction

   // Reference: cycle index (after T0) at which res_valid appears.
   function automatic int ref_lat(input logic [W-1:0] b);
`ifdef MULT_EARLY_EXIT_EN
      int msb;
      if (b == 0) return 1;
      msb = 0;
      for (int i = 0; i < W; i++) if (b[i]) msb = i;
      return msb + 2;
`else
      return W + 1;
`endif
   endfunction

   // Issue a MUL at T0 and follow it to its DONE cycle; instruction stays presented.
   task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b);
      int lat;
      logic [W-1:0] exp;
      lat = ref_lat(b);
      exp = ref_prod(a, b);
      @(posedge clk); #1;
      flush = 1'b0; ex_valid = 1'b1; mult_sel = 1'b1; src_a = a; src_b = b;
      @(negedge clk);
      chk("t0_stall", {31'b0, stall}, 1);
      chk("t0_busy", {31'b0, busy}, 0);
      for (int t = 1; t <= lat; t++) begin
         @(negedge clk);
         chk("busy", {31'b0, busy}, 1);
         if (t < lat) begin
            chk("stall_run", {31'b0, stall}, 1);
            chk("no_early_valid", {31'b0, res_valid}, 0);
         end else begin
            chk("done_valid", {31'b0, res_valid}, 1);
            chk("done_res", res, exp);
            chk("done_stall", {31'b0, stall}, 0);
         end
      end
   endtask

   // Drop the instruction and check the result is held with no second pulse.
   task automatic idle_cycle(input logic [W-1:0] held);
      @(posedge clk); #1;
      ex_valid = 1'b0; mult_sel = 1'b0;
      @(negedge clk);
      chk("idle_valid", {31'b0, res_valid}, 0);
      chk("idle_busy", {31'b0, busy}, 0);
      chk("idle_hold", res, held);
   endtask

   initial begin
      logic [W-1:0] a, b;
      // Reset state
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_stall", {31'b0, stall}, 0);
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_valid", {31'b0, res_valid}, 0);
      chk("rst_res", res, 0);

      // Basic, wrap, signed
      run_mul(32'd7, 32'd6);                 idle_cycle(32'd42);
      run_mul(32'hFFFFFFFF, 32'hFFFFFFFF);   idle_cycle(32'h00000001);
      run_mul(32'hFFFFFFFD, 32'd5);          idle_cycle(32'hFFFFFFF1);

      // Early-exit shaped operands (latency differs by build, result does not)
      run_mul(32'd1234, 32'd0);              idle_cycle(32'd0);
      run_mul(32'd9, 32'd2);                 idle_cycle(32'd18);

      // Back-to-back: second MUL enters the cycle after DONE
      run_mul(32'd3, 32'd4);
      run_mul(32'd5, 32'd5);                 idle_cycle(32'd25);

      // Flush at T10 of a full-length multiply, then a new MUL at T11
      @(posedge clk); #1;
      ex_valid = 1'b1; mult_sel = 1'b1; src_a = 32'd11; src_b = 32'h80000001;
      for (int t = 1; t <= 9; t++) @(negedge clk);
      chk("pre_flush_stall", {31'b0, stall}, 1);
      @(posedge clk); #1 flush = 1'b1;
      @(negedge clk);
      chk("flush_stall", {31'b0, stall}, 0);
      chk("flush_valid", {31'b0, res_valid}, 0);
      run_mul(32'd13, 32'd17);               idle_cycle(32'd221);

      // Reset during T15 of a multiply
      @(posedge clk); #1;
      ex_valid = 1'b1; mult_sel = 1'b1; src_a = 32'd100; src_b = 32'hC0000003;
      for (int t = 1; t <= 14; t++) @(negedge clk);
      @(posedge clk); #1 rst_n = 1'b0;
      @(negedge clk);
      chk("inrst_stall", {31'b0, stall}, 0);
      chk("inrst_busy", {31'b0, busy}, 0);
      @(posedge clk); #1 rst_n = 1'b1; ex_valid = 1'b0; mult_sel = 1'b0;
      @(negedge clk);
      chk("postrst_busy", {31'b0, busy}, 0);
      chk("postrst_stall", {31'b0, stall}, 0);
      chk("postrst_valid", {31'b0, res_valid}, 0);
      chk("postrst_res", res, 0);
      run_mul(32'd77, 32'd3);                idle_cycle(32'd231);

      // Random multiplies with varied multiplier width
      for (int n = 0; n < 10; n++) begin
         a = $urandom;
         b = $urandom >> $urandom_range(0, 31);
         run_mul(a, b);
         idle_cycle(ref_prod(a, b));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
